// File: rtl/i2c_target_regs.sv
// I2C target (7-bit address, no clock stretching) exposing a 2**REG_AW x 8 register file.
// The same registers are also readable and writable from fabric through a single-cycle local port.
module i2c_target_regs #(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         REG_AW      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  input  logic [REG_AW-1:0] loc_addr,
  input  logic              loc_we,
  input  logic [7:0]        loc_wdata,
  output logic [7:0]        loc_rdata,
  output logic              i2c_wr_pulse,
  output logic [REG_AW-1:0] i2c_wr_addr,
  output logic              busy,
  output logic [3:0]        state_dbg
);

  localparam int NREG = 1 << REG_AW;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_ADDR     = 4'd1;
  localparam logic [3:0] S_ADDR_ACK = 4'd2;
  localparam logic [3:0] S_PTR      = 4'd3;
  localparam logic [3:0] S_PTR_ACK  = 4'd4;
  localparam logic [3:0] S_WR_DATA  = 4'd5;
  localparam logic [3:0] S_WR_ACK   = 4'd6;
  localparam logic [3:0] S_RD_DATA  = 4'd7;
  localparam logic [3:0] S_RD_ACK   = 4'd8;
  localparam logic [3:0] S_RD_WAIT  = 4'd9;

  logic [7:0]        regs [NREG];
  logic [3:0]        state;
  logic [3:0]        bit_cnt;
  logic [7:0]        shreg;
  logic [REG_AW-1:0] ptr;
  logic              scl_m, scl_s, scl_q;
  logic              sda_m, sda_s, sda_q;
  logic              start_det, stop_det, scl_rise, scl_fall, commit;

  // Synchronizers and previous-cycle copies idle high, matching a released bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {scl_m, scl_s, scl_q} <= 3'b111;
      {sda_m, sda_s, sda_q} <= 3'b111;
    end else begin
      {scl_m, scl_s, scl_q} <= {scl_in, scl_m, scl_s};
      {sda_m, sda_s, sda_q} <= {sda_in, sda_m, sda_s};
    end
  end

  assign start_det = scl_s & sda_q & ~sda_s;
  assign stop_det  = scl_s & ~sda_q & sda_s;
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign commit    = (state == S_WR_DATA) && scl_fall && (bit_cnt == 4'd8) && !start_det && !stop_det;

  assign loc_rdata = regs[loc_addr];
  assign state_dbg = state;

  // Local port: loc_we is a one-cycle strobe with no back-pressure; the write lands on the next edge.
  // The I2C commit is assigned last so it wins a same-cycle collision on one register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= 8'h00;
    end else begin
      if (loc_we) regs[loc_addr] <= loc_wdata;
      if (commit) regs[ptr] <= shreg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      bit_cnt      <= 4'd0;
      shreg        <= 8'h00;
      ptr          <= '0;
      sda_oe       <= 1'b0;
      busy         <= 1'b0;
      i2c_wr_pulse <= 1'b0;
      i2c_wr_addr  <= '0;
    end else begin
      i2c_wr_pulse <= 1'b0;
      if (start_det) begin
        state   <= S_ADDR;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
      end else if (stop_det) begin
        state  <= S_IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          S_ADDR: begin
            if (scl_rise && bit_cnt < 4'd8) begin
              shreg   <= {shreg[6:0], sda_s};
              bit_cnt <= bit_cnt + 4'd1;
              // shreg[6:0] holds the 7 address bits once the R/W bit is arriving.
              if (bit_cnt == 4'd7 && shreg[6:0] != TARGET_ADDR) state <= S_IDLE;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              sda_oe <= 1'b1;
              busy   <= 1'b1;
              state  <= S_ADDR_ACK;
            end
          end
          S_ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= 4'd0;
              if (!shreg[0]) begin
                sda_oe <= 1'b0;
                state  <= S_PTR;
              end else begin
                shreg  <= regs[ptr];
                sda_oe <= ~regs[ptr][7];
                state  <= S_RD_DATA;
              end
            end
          end
          S_PTR, S_WR_DATA: begin
            if (scl_rise && bit_cnt < 4'd8) begin
              shreg   <= {shreg[6:0], sda_s};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              sda_oe <= 1'b1;
              if (state == S_PTR) begin
                ptr   <= shreg[REG_AW-1:0];
                state <= S_PTR_ACK;
              end else begin
                i2c_wr_pulse <= 1'b1;
                i2c_wr_addr  <= ptr;
                ptr          <= ptr + REG_AW'(1);
                state        <= S_WR_ACK;
              end
            end
          end
          S_PTR_ACK, S_WR_ACK: begin
            if (scl_fall) begin
              sda_oe  <= 1'b0;
              bit_cnt <= 4'd0;
              state   <= S_WR_DATA;
            end
          end
          S_RD_DATA: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd7) begin
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
                state   <= S_RD_ACK;
              end else begin
                sda_oe  <= ~shreg[6];
                shreg   <= {shreg[6:0], 1'b0};
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          S_RD_ACK: begin
            // bit_cnt == 8 marks "controller ACKed, pointer already advanced".
            if (scl_rise && bit_cnt == 4'd0) begin
              if (!sda_s) begin
                ptr     <= ptr + REG_AW'(1);
                bit_cnt <= 4'd8;
              end else begin
                state <= S_RD_WAIT;
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              shreg   <= regs[ptr];
              sda_oe  <= ~regs[ptr][7];
              bit_cnt <= 4'd0;
              state   <= S_RD_DATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
